// File: rtl/sqrt_ctrl_pkg.sv
// Shared encodings for the Newton-Raphson square-root controller:
// state codes, AU opcodes, register indices and bus-source bit positions.
package sqrt_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_LOAD     = 4'd1,
        S_INIT     = 4'd2,
        S_DIV_GO   = 4'd3,
        S_DIV_WAIT = 4'd4,
        S_ADD      = 4'd5,
        S_HALF     = 4'd6,
        S_CHECK    = 4'd7,
        S_OUT      = 4'd8,
        S_DONE     = 4'd9
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_SHR = 2'd2,
        OP_DIV = 2'd3
    } au_op_t;

    // Register file map: S, current estimate x, scratch
    localparam int unsigned R0 = 32'd0;
    localparam int unsigned R1 = 32'd1;
    localparam int unsigned R2 = 32'd2;

    localparam int unsigned TRI_EXT = 32'd0;
    localparam int unsigned TRI_AU  = 32'd1;
    localparam int unsigned TRI_OUT = 32'd2;

endpackage

// File: rtl/sqrt_ctrl_decode.sv
// Combinational state -> control-word decode. All outputs are Moore except
// the R2 write in DIV_WAIT, which follows au_ready in the same cycle.
module sqrt_ctrl_decode
    import sqrt_ctrl_pkg::*;
#(
    parameter int AW = 3,
    parameter int TW = 10
) (
    input  state_t          state,
    input  logic            au_ready,
    output logic            we,
    output logic [AW-1:0]   wa,
    output logic            re_a,
    output logic            re_b,
    output logic [AW-1:0]   ra_a,
    output logic [AW-1:0]   ra_b,
    output logic [1:0]      au_op,
    output logic            au_go,
    output logic            oe,
    output logic [TW-1:0]   trictrl,
    output logic            busy,
    output logic            done
);

    // Control word for the current state; every field defaults to 0
    always_comb begin
        we      = 1'b0;
        wa      = '0;
        re_a    = 1'b0;
        re_b    = 1'b0;
        ra_a    = '0;
        ra_b    = '0;
        au_op   = OP_ADD;
        au_go   = 1'b0;
        oe      = 1'b0;
        trictrl = '0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_LOAD: begin
                busy             = 1'b1;
                we               = 1'b1;
                wa               = AW'(R0);
                trictrl[TRI_EXT] = 1'b1;
            end
            S_INIT: begin
                busy            = 1'b1;
                re_a            = 1'b1;
                ra_a            = AW'(R0);
                au_op           = OP_SHR;
                we              = 1'b1;
                wa              = AW'(R1);
                trictrl[TRI_AU] = 1'b1;
            end
            S_DIV_GO: begin
                busy  = 1'b1;
                re_a  = 1'b1;
                ra_a  = AW'(R0);
                re_b  = 1'b1;
                ra_b  = AW'(R1);
                au_op = OP_DIV;
                au_go = 1'b1;
            end
            S_DIV_WAIT: begin
                busy  = 1'b1;
                re_a  = 1'b1;
                ra_a  = AW'(R0);
                re_b  = 1'b1;
                ra_b  = AW'(R1);
                au_op = OP_DIV;
                if (au_ready) begin
                    we              = 1'b1;
                    wa              = AW'(R2);
                    trictrl[TRI_AU] = 1'b1;
                end else begin
                    we = 1'b0;
                end
            end
            S_ADD: begin
                busy            = 1'b1;
                re_a            = 1'b1;
                ra_a            = AW'(R2);
                re_b            = 1'b1;
                ra_b            = AW'(R1);
                au_op           = OP_ADD;
                we              = 1'b1;
                wa              = AW'(R2);
                trictrl[TRI_AU] = 1'b1;
            end
            S_HALF: begin
                busy            = 1'b1;
                re_a            = 1'b1;
                ra_a            = AW'(R2);
                au_op           = OP_SHR;
                we              = 1'b1;
                wa              = AW'(R1);
                trictrl[TRI_AU] = 1'b1;
            end
            S_CHECK: begin
                busy = 1'b1;
            end
            S_OUT: begin
                busy             = 1'b1;
                re_a             = 1'b1;
                ra_a             = AW'(R1);
                oe               = 1'b1;
                trictrl[TRI_OUT] = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/sqrt_iter_ctrl.sv
// Newton-Raphson square-root sequencer: state register, next-state logic with
// abort/convergence/iteration-limit exits, and the completed-iteration counter.
module sqrt_iter_ctrl
    import sqrt_ctrl_pkg::*;
#(
    parameter int AW     = 3,
    parameter int N_ITER = 4,
    parameter int TW     = 10,
    parameter int CW     = $clog2(N_ITER + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic            au_ready,
    input  logic            conv,
    output logic            we,
    output logic [AW-1:0]   wa,
    output logic            re_a,
    output logic            re_b,
    output logic [AW-1:0]   ra_a,
    output logic [AW-1:0]   ra_b,
    output logic [1:0]      au_op,
    output logic            au_go,
    output logic            oe,
    output logic [TW-1:0]   trictrl,
    output logic            busy,
    output logic            done,
    output logic [CW-1:0]   iter,
    output logic [3:0]      state
);

    localparam logic [CW-1:0] ITER_MAX = CW'(N_ITER);

    state_t          state_r;
    state_t          state_nxt;
    logic [CW-1:0]   iter_r;
    logic            launch_s;

    assign launch_s = (state_r == S_IDLE) && start && !abort;

    // Next state; abort wins over every other input outside IDLE
    always_comb begin
        state_nxt = S_IDLE;
        if (state_r == S_IDLE) begin
            state_nxt = launch_s ? S_LOAD : S_IDLE;
        end else if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state_r)
                S_LOAD:     state_nxt = S_INIT;
                S_INIT:     state_nxt = S_DIV_GO;
                S_DIV_GO:   state_nxt = S_DIV_WAIT;
                S_DIV_WAIT: state_nxt = au_ready ? S_ADD : S_DIV_WAIT;
                S_ADD:      state_nxt = S_HALF;
                S_HALF:     state_nxt = S_CHECK;
                S_CHECK:    state_nxt = (conv || (iter_r == ITER_MAX)) ? S_OUT : S_DIV_GO;
                S_OUT:      state_nxt = S_DONE;
                S_DONE:     state_nxt = start ? S_DONE : S_IDLE;
                default:    state_nxt = S_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Iteration counter: cleared on launch, bumped when HALF completes
    always_ff @(posedge clk) begin
        if (rst) begin
            iter_r <= '0;
        end else if (launch_s) begin
            iter_r <= '0;
        end else if ((state_r == S_HALF) && !abort) begin
            iter_r <= iter_r + CW'(1);
        end else begin
            iter_r <= iter_r;
        end
    end

    assign iter  = iter_r;
    assign state = state_r;

    sqrt_ctrl_decode #(
        .AW (AW),
        .TW (TW)
    ) u_decode (
        .state    (state_r),
        .au_ready (au_ready),
        .we       (we),
        .wa       (wa),
        .re_a     (re_a),
        .re_b     (re_b),
        .ra_a     (ra_a),
        .ra_b     (ra_b),
        .au_op    (au_op),
        .au_go    (au_go),
        .oe       (oe),
        .trictrl  (trictrl),
        .busy     (busy),
        .done     (done)
    );

endmodule

// File: tb/tb_sqrt_iter_ctrl.sv
// Self-checking bench: builds the expected per-cycle trace of an operation from
// its schedule (divider stalls, convergence, abort point) and replays it.
module tb_sqrt_iter_ctrl;

    localparam int AW = 3;
    localparam int N_ITER = 4;
    localparam int TW = 10;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic au_ready = 1'b0;
    logic conv = 1'b0;
    logic we, re_a, re_b, au_go, oe, busy, done;
    logic [AW-1:0] wa, ra_a, ra_b;
    logic [1:0] au_op;
    logic [TW-1:0] trictrl;
    logic [CW-1:0] iter;
    logic [3:0] state;

    typedef struct packed {
        logic we; logic [2:0] wa; logic re_a; logic [2:0] ra_a; logic re_b; logic [2:0] ra_b;
        logic [1:0] au_op; logic au_go; logic oe; logic [9:0] trictrl; logic busy; logic done;
    } ctrl_t;

    typedef struct {
        int st; int it; bit start; bit ab; bit ar; bit cv;
    } step_t;

    ctrl_t obs;
    step_t q[$];
    int tests_run = 0;
    int tests_failed = 0;

    assign obs = {we, wa, re_a, ra_a, re_b, ra_b, au_op, au_go, oe, trictrl, busy, done};

    always #5 clk = ~clk;

    sqrt_iter_ctrl #(.AW(AW), .N_ITER(N_ITER), .TW(TW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .au_ready(au_ready), .conv(conv),
        .we(we), .wa(wa), .re_a(re_a), .re_b(re_b), .ra_a(ra_a), .ra_b(ra_b),
        .au_op(au_op), .au_go(au_go), .oe(oe), .trictrl(trictrl), .busy(busy),
        .done(done), .iter(iter), .state(state)
    );

    // Control word each state must present (from the state/decode table)
    function automatic ctrl_t exp_ctrl(input int st, input bit ar);
        ctrl_t c;
        c = '0;
        c.busy = (st >= 1 && st <= 8);
        case (st)
            1: begin c.we = 1; c.wa = 3'd0; c.trictrl = 10'b001; end
            2: begin c.re_a = 1; c.ra_a = 3'd0; c.au_op = 2'd2; c.we = 1; c.wa = 3'd1; c.trictrl = 10'b010; end
            3: begin c.re_a = 1; c.ra_a = 3'd0; c.re_b = 1; c.ra_b = 3'd1; c.au_op = 2'd3; c.au_go = 1; end
            4: begin
                c.re_a = 1; c.ra_a = 3'd0; c.re_b = 1; c.ra_b = 3'd1; c.au_op = 2'd3;
                if (ar) begin c.we = 1; c.wa = 3'd2; c.trictrl = 10'b010; end
            end
            5: begin c.re_a = 1; c.ra_a = 3'd2; c.re_b = 1; c.ra_b = 3'd1; c.au_op = 2'd0; c.we = 1; c.wa = 3'd2; c.trictrl = 10'b010; end
            6: begin c.re_a = 1; c.ra_a = 3'd2; c.au_op = 2'd2; c.we = 1; c.wa = 3'd1; c.trictrl = 10'b010; end
            8: begin c.re_a = 1; c.ra_a = 3'd1; c.oe = 1; c.trictrl = 10'b100; end
            9: c.done = 1;
            default: c = c;
        endcase
        return c;
    endfunction

    // Appends one expected cycle; on the chosen abort point also appends the IDLE that follows
    function automatic bit add(input int st, input int it, input bit ar, input bit cv,
                               input int k, input int abort_iter, input int abort_st);
        step_t e;
        bit hit;
        hit = (k == abort_iter) && (st == abort_st);
        e.st = st; e.it = it; e.start = 1'b0; e.ab = hit; e.ar = ar; e.cv = cv;
        q.push_back(e);
        if (hit) begin
            e.st = 0; e.ab = 1'b0; e.ar = 1'($urandom); e.cv = 1'($urandom);
            q.push_back(e);
        end
        return hit;
    endfunction

    task automatic build(input int conv_at, input int stall_min, input int stall_max,
                         input int abort_iter, input int abort_st, input int hold);
        int k;
        int d;
        step_t e;
        q.delete();
        if (add(1, 0, 1'($urandom), 1'($urandom), 1, abort_iter, abort_st)) return;
        if (add(2, 0, 1'($urandom), 1'($urandom), 1, abort_iter, abort_st)) return;
        for (k = 1; k <= N_ITER; k++) begin
            if (add(3, k - 1, 1'($urandom), 1'($urandom), k, abort_iter, abort_st)) return;
            d = $urandom_range(stall_max, stall_min);
            for (int j = 0; j < d; j++)
                if (add(4, k - 1, 1'b0, 1'($urandom), k, abort_iter, abort_st)) return;
            if (add(4, k - 1, 1'b1, 1'($urandom), k, abort_iter, abort_st)) return;
            if (add(5, k - 1, 1'($urandom), 1'($urandom), k, abort_iter, abort_st)) return;
            if (add(6, k - 1, 1'($urandom), 1'($urandom), k, abort_iter, abort_st)) return;
            if (add(7, k, 1'($urandom), (k == conv_at), k, abort_iter, abort_st)) return;
            if (k == conv_at || k == N_ITER) break;
        end
        if (add(8, k, 1'($urandom), 1'($urandom), k, abort_iter, abort_st)) return;
        for (int h = 0; h < hold; h++) begin
            e.st = 9; e.it = k; e.start = 1'b1; e.ab = 1'b0; e.ar = 1'($urandom); e.cv = 1'($urandom);
            q.push_back(e);
        end
        e.st = 9; e.it = k; e.start = 1'b0; e.ab = 1'b0; e.ar = 1'($urandom); e.cv = 1'($urandom);
        q.push_back(e);
        e.st = 0;
        q.push_back(e);
    endtask

    // Launches from IDLE and compares every cycle of the expected trace
    task automatic play(output int done_cycle, output int go_count);
        ctrl_t ex;
        done_cycle = -1;
        go_count = 0;
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b0; au_ready = 1'($urandom); conv = 1'($urandom);
        #1;
        tests_run++;
        if (state !== 4'd0) begin
            tests_failed++;
            $display("FAIL idle_before_start: state=%0d expected 0", state);
        end
        for (int i = 0; i < q.size(); i++) begin
            @(posedge clk); #1;
            start = q[i].start; abort = q[i].ab; au_ready = q[i].ar; conv = q[i].cv;
            #1;
            ex = exp_ctrl(q[i].st, q[i].ar);
            tests_run++;
            if (state !== 4'(q[i].st) || iter !== CW'(q[i].it) || obs !== ex) begin
                tests_failed++;
                $display("FAIL trace[%0d]: state=%0d iter=%0d ctrl=%h expected state=%0d iter=%0d ctrl=%h",
                         i, state, iter, obs, q[i].st, q[i].it, ex);
            end
            if (done === 1'b1 && done_cycle < 0) done_cycle = i + 1;
            if (au_go === 1'b1) go_count++;
        end
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; au_ready = 1'b1; conv = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (state !== 4'd0 || iter !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: state=%0d iter=%0d expected 0/0", state, iter);
        end
        tests_run++;
        if (obs !== '0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: ctrl=%h expected 0", obs);
        end
        rst = 1'b0; start = 1'b0;
        // Mid-operation reset
        @(posedge clk); #1 start = 1'b1;
        repeat (7) @(posedge clk);
        #1 start = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (state !== 4'd0 || iter !== '0 || obs !== '0) begin
            tests_failed++;
            $display("FAIL reset_midrun: state=%0d iter=%0d ctrl=%h expected all 0", state, iter, obs);
        end
        rst = 1'b0; au_ready = 1'b0; conv = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_full_run();
        int dc, gc;
        build(0, 0, 0, 0, 0, 0);
        play(dc, gc);
        tests_run++;
        if (dc !== 24) begin
            tests_failed++;
            $display("FAIL full_run_latency: done at %0d expected 24", dc);
        end
        tests_run++;
        if (gc !== N_ITER) begin
            tests_failed++;
            $display("FAIL full_run_au_go: pulses=%0d expected %0d", gc, N_ITER);
        end
    endtask

    task automatic test_early_exit();
        int dc, gc;
        build(1, 0, 0, 0, 0, 0);
        play(dc, gc);
        tests_run++;
        if (dc !== 9) begin
            tests_failed++;
            $display("FAIL early_exit_latency: done at %0d expected 9", dc);
        end
    endtask

    task automatic test_stall();
        int dc, gc;
        build(2, 3, 3, 0, 0, 0);
        play(dc, gc);
        tests_run++;
        if (dc !== 20 || gc !== 2) begin
            tests_failed++;
            $display("FAIL stall: done at %0d go=%0d expected 20/2", dc, gc);
        end
    endtask

    task automatic test_abort();
        int dc, gc;
        build(0, 0, 2, 2, 5, 0);
        play(dc, gc);
        tests_run++;
        if (dc !== -1 || gc !== 2 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort: done_cycle=%0d go=%0d busy=%0b expected -1/2/0", dc, gc, busy);
        end
        build(0, 0, 1, 0, 0, 0);
        play(dc, gc);
        tests_run++;
        if (dc < 0 || gc !== N_ITER) begin
            tests_failed++;
            $display("FAIL restart_after_abort: done_cycle=%0d go=%0d expected done, %0d", dc, gc, N_ITER);
        end
    endtask

    task automatic test_done_hold();
        int dc, gc;
        build(3, 0, 1, 0, 0, 3);
        play(dc, gc);
        @(posedge clk); #1 start = 1'b1; abort = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (state !== 4'd0 || done !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL start_with_abort: state=%0d done=%0b expected IDLE", state, done);
        end
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic test_back_to_back();
        int dc, gc, ai, as;
        for (int r = 0; r < 8; r++) begin
            ai = ($urandom_range(2, 0) == 0) ? $urandom_range(N_ITER, 1) : 0;
            as = $urandom_range(8, 1);
            build($urandom_range(N_ITER, 0), 0, 4, ai, as, $urandom_range(2, 0));
            play(dc, gc);
        end
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_early_exit();
        test_stall();
        test_abort();
        test_done_hold();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
